ftop_oc_ram_arbiter: RTL and testbench
======================================

# ftop_oc_ram_arbiter

Two-port arbiter that shares one single-port on-chip RAM (12-bit word address, 32-bit data, byte enables, 1-cycle read latency) between two Avalon-MM requesters, such as the data masters of two CPU cores in the multiprocessor SoC. It sits between the interconnect and the RAM's single slave port. It grants one transfer per cycle with round-robin fairness and an optional lock. It returns read data with a per-port readdatavalid.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LOCK_MAX, 8, maximum consecutive locked grants before forced release (used only with lock compiled in)

Ports (N in {0,1}; each line applies to both requester ports):
- clk  in  1  single clock; all logic is on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- mN_address  in  ADDR_W  word address
- mN_byteenable  in  DATA_W/8  byte lanes for writes
- mN_read  in  1  read request
- mN_write  in  1  write request; if read and write are both asserted, the write wins
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  request to keep the grant next cycle (ignored without FTOP_OC_RAM_ARB_LOCK_EN)
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid only with readdatavalid
- mN_readdatavalid  out  1  one-cycle pulse per accepted read
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM; all ones on reads
- ram_chipselect  out  1  high when a transfer is granted
- ram_write  out  1  granted write
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  RAM clock enable; constant 1 while reset_n is high
- ram_readdata  in  DATA_W  RAM q; valid in the cycle after the address was sampled

## Operation
- A port requests when mN_read or mN_write is high.
- Per cycle, exactly zero or one port is granted. The grant is combinational from the current requests, the registered priority pointer `prio`, and the arbiter state.
- Round robin: with one requester, that port is granted. With both requesting, port `prio` is granted. After any grant, `prio` becomes the other port.
- For the granted port: waitrequest=0, and its command is muxed onto the ram_* outputs with ram_chipselect=1.
- For a non-granted requesting port: waitrequest=1, and it must hold its command stable.
- For an idle port: waitrequest=0, so no bubble is added to its next request.
- Read return: a registered `rd_pend[N]` is set for the cycle after an accepted read. That cycle drives mN_readdatavalid=1 and mN_readdata=ram_readdata. readdata for the other port is don't-care, driven 0.
- Back-to-back reads from the same or alternating ports are accepted every cycle; returns follow in acceptance order.
- State machine `arb_st`, relevant only with lock compiled in:
  - FREE: round robin as above. A granted transfer with mN_lock=1 moves to LOCKN with lock_cnt=1.
  - LOCKN: only port N can be granted; the other port's waitrequest=1.
    - Stay in LOCKN while port N requests with lock=1 and lock_cnt<LOCK_MAX; lock_cnt increments on each grant.
    - Return to FREE when lock deasserts, when port N is idle for one cycle, or when lock_cnt==LOCK_MAX. In the LOCK_MAX case, `prio` points to the other port.
- Reset (asynchronous, any time):
  - prio=0, arb_st=FREE, lock_cnt=0, rd_pend=0.
  - Any read in flight is dropped with no readdatavalid.
  - All outputs are 0 while reset_n=0, except mN_waitrequest=1.

## Timing
- Write: accepted in cycle T (waitrequest=0); the RAM commits at the rising edge ending T.
- Read: accepted in T; mN_readdatavalid and mN_readdata in T+1. Latency is fixed at 1 and there is no backpressure on the return path.
- Worst-case wait with both ports continuously requesting: 1 cycle without lock, LOCK_MAX cycles with lock.
- Read followed by write from the other port in T+1: the write is granted in T+1, and the T+1 readdatavalid belongs to the T read.

## Configuration
- FTOP_OC_RAM_ARB_LOCK_EN defined: mN_lock is honoured, and the LOCK0/LOCK1 states, lock_cnt, and the LOCK_MAX release are present.
- Not defined: mN_lock is ignored, arb_st is fixed at FREE, and there is no lock_cnt register. Arbitration is pure round robin.

## Structure
- Package ftop_oc_ram_arb_pkg holds:
  - the arb_st enum (FREE, LOCK0, LOCK1)
  - the port index type
  - the localparam for byteenable width
- Sub-module ftop_oc_ram_arb_rr: 2-way round-robin grant with the `prio` register, plus the lock state machine. The top level holds the command mux, rd_pend, and the return demux.

## Test plan
- Reset release, then m0 reads address 0x010 holding 0xDEADBEEF -> m0_waitrequest=0 in T, m0_readdatavalid=1 with 0xDEADBEEF in T+1, m1 signals quiet.
- m0 and m1 both write every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each port sees waitrequest=1 every other cycle; RAM contents match all 6 writes.
- m0 writes 0x12345678 with byteenable 0x3 to 0x020, which held 0xAAAAAAAA, then m1 reads 0x020 -> m1_readdata=0xAAAA5678 one cycle after its grant.
- Lock compiled in, LOCK_MAX=8: m0 holds lock and writes continuously while m1 requests -> m0 gets 8 consecutive grants, then m1 is granted on the 9th cycle.
- reset_n asserted in the cycle after an accepted m1 read -> no m1_readdatavalid; after release, waitrequest=0 and the first grant with both ports requesting goes to m0.
- Without the macro: m0_lock=1 with both ports requesting -> strict alternation, lock ignored.

Source files
------------

// File: rtl/ftop_oc_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftop_oc_ram_arb_pkg
// Description : Shared types for the two-port on-chip RAM arbiter.
//               - arb_st_t   : arbiter state (FREE, LOCK0, LOCK1)
//               - port_idx_t : index of a requester port (0 or 1)
//               - BE_W       : byteenable width for the default data width
//               - be_width() : byteenable width for any data width
//               The lock states are only reachable when the design is built
//               with FTOP_OC_RAM_ARB_LOCK_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
package ftop_oc_ram_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_st_t;

    typedef logic port_idx_t;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned BE_W           = DATA_W_DEFAULT / 8;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ftop_oc_ram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : ftop_oc_ram_arb_rr
// Description : 2-way round-robin grant generator with the registered
//               priority pointer and, when FTOP_OC_RAM_ARB_LOCK_EN is
//               defined, the lock state machine with LOCK_MAX release.
//               Without the macro the lock inputs are ignored and the
//               arbiter is pure round robin.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               req[1:0] - per-port request (read or write)
//               lock[1:0]- per-port lock request
//               gnt[1:0] - one-hot (or zero) grant, combinational
//               blocked  - port held off by the other port's lock
// Revision    : 1.0 - initial release
// ============================================================================
module ftop_oc_ram_arb_rr
    import ftop_oc_ram_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic [1:0] blocked
);

    port_idx_t  prio;
    logic [1:0] gnt_rr;
    logic [1:0] gnt_c;

    // Plain round robin: a lone requester wins, a tie goes to prio.
    always_comb begin
        gnt_rr = 2'b00;
        if (req == 2'b11) begin
            gnt_rr[prio] = 1'b1;
        end else begin
            gnt_rr = req;
        end
    end

`ifdef FTOP_OC_RAM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_st_t          arb_st;
    arb_st_t          arb_st_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic [CNT_W-1:0] lock_cnt_inc;

    assign lock_cnt_inc = lock_cnt + CNT_W'(1);

    always_comb begin
        arb_st_nxt   = arb_st;
        lock_cnt_nxt = lock_cnt;
        gnt_c        = 2'b00;
        blocked      = 2'b00;
        case (arb_st)
            FREE: begin
                gnt_c = gnt_rr;
                // With LOCK_MAX==1 a single grant already exhausts the lock.
                if (LOCK_MAX > 1) begin
                    if (gnt_rr[0] && lock[0]) begin
                        arb_st_nxt   = LOCK0;
                        lock_cnt_nxt = CNT_W'(1);
                    end else if (gnt_rr[1] && lock[1]) begin
                        arb_st_nxt   = LOCK1;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCK0: begin
                blocked[1] = 1'b1;
                gnt_c[0]   = req[0];
                if (!req[0] || !lock[0] || (32'(lock_cnt_inc) >= LOCK_MAX)) begin
                    arb_st_nxt   = FREE;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt_inc;
                end
            end
            LOCK1: begin
                blocked[0] = 1'b1;
                gnt_c[1]   = req[1];
                if (!req[1] || !lock[1] || (32'(lock_cnt_inc) >= LOCK_MAX)) begin
                    arb_st_nxt   = FREE;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt_inc;
                end
            end
            default: begin
                arb_st_nxt   = FREE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_st   <= FREE;
            lock_cnt <= '0;
        end else begin
            arb_st   <= arb_st_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end
`else
    logic lock_unused;

    assign lock_unused = ^lock;
    assign gnt_c       = gnt_rr;
    assign blocked     = 2'b00;
`endif

    // No grant is ever issued while reset is asserted.
    assign gnt = reset_n ? gnt_c : 2'b00;

    // Every grant hands priority to the other port; this also gives the
    // LOCK_MAX release its hand-over to the waiting port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ftop_oc_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ftop_oc_ram_arbiter
// Description : Shares one single-port on-chip RAM (1-cycle read latency)
//               between two Avalon-MM requesters. One transfer per cycle,
//               round-robin fair, optional lock (FTOP_OC_RAM_ARB_LOCK_EN).
//               Read data is returned with a per-port readdatavalid pulse.
// Ports       : clk, reset_n (async, active-low)
//               mN_address/byteenable/read/write/writedata/lock  - requests
//               mN_waitrequest/readdata/readdatavalid            - responses
//               ram_address/byteenable/chipselect/write/writedata/clken
//                                                                - to RAM
//               ram_readdata                                     - RAM q
// Revision    : 1.0 - initial release
// ============================================================================
module ftop_oc_ram_arbiter
    import ftop_oc_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam int unsigned BEW = be_width(DATA_W);

    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] blocked;
    logic [1:0] rd_pend;
    port_idx_t  sel;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    ftop_oc_ram_arb_rr #(
        .LOCK_MAX (LOCK_MAX)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .lock    ({m1_lock, m0_lock}),
        .gnt     (gnt),
        .blocked (blocked)
    );

    // Grant is one-hot or zero, so gnt[1] alone selects the command source.
    assign sel = gnt[1];

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        if (gnt != 2'b00) begin
            ram_chipselect = 1'b1;
            if (sel == 1'b0) begin
                ram_address    = m0_address;
                ram_write      = m0_write;
                ram_writedata  = m0_write ? m0_writedata : '0;
                ram_byteenable = m0_write ? m0_byteenable : {BEW{1'b1}};
            end else begin
                ram_address    = m1_address;
                ram_write      = m1_write;
                ram_writedata  = m1_write ? m1_writedata : '0;
                ram_byteenable = m1_write ? m1_byteenable : {BEW{1'b1}};
            end
        end
    end

    // Write wins over read, so a read is only pending when write is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend[0] <= gnt[0] & m0_read & ~m0_write;
            rd_pend[1] <= gnt[1] & m1_read & ~m1_write;
        end
    end

    assign m0_readdatavalid = rd_pend[0];
    assign m1_readdatavalid = rd_pend[1];
    assign m0_readdata      = rd_pend[0] ? ram_readdata : '0;
    assign m1_readdata      = rd_pend[1] ? ram_readdata : '0;

    // Idle ports see waitrequest low so their next request has no bubble.
    assign m0_waitrequest = ~reset_n | (req[0] & ~gnt[0]) | blocked[0];
    assign m1_waitrequest = ~reset_n | (req[1] & ~gnt[1]) | blocked[1];

    assign ram_clken = reset_n;

endmodule
`default_nettype wire

// File: tb/tb_ftop_oc_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftop_oc_ram_arbiter
// Description : Self-checking bench for ftop_oc_ram_arbiter with a
//               behavioural 1-cycle-latency RAM and a shadow memory that
//               supplies expected read data into per-port scoreboards.
//               The lock scenario is selected by FTOP_OC_RAM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftop_oc_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        rd   [2];
    logic        wr   [2];
    logic        lk   [2];
    logic [11:0] addr [2];
    logic [3:0]  be   [2];
    logic [31:0] wd   [2];

    logic        wreq [2];
    logic        rv   [2];
    logic [31:0] rdat [2];

    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_rdata;

    logic [31:0] mem    [0:4095];
    logic [31:0] shadow [0:4095];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          seq [$];
    logic        exp_prio;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    ftop_oc_ram_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .LOCK_MAX (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (addr[0]),
        .m0_byteenable    (be[0]),
        .m0_read          (rd[0]),
        .m0_write         (wr[0]),
        .m0_writedata     (wd[0]),
        .m0_lock          (lk[0]),
        .m0_waitrequest   (wreq[0]),
        .m0_readdata      (rdat[0]),
        .m0_readdatavalid (rv[0]),
        .m1_address       (addr[1]),
        .m1_byteenable    (be[1]),
        .m1_read          (rd[1]),
        .m1_write         (wr[1]),
        .m1_writedata     (wd[1]),
        .m1_lock          (lk[1]),
        .m1_waitrequest   (wreq[1]),
        .m1_readdata      (rdat[1]),
        .m1_readdatavalid (rv[1]),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_rdata)
    );

    // Behavioural single-port RAM: write commits at the edge, q one cycle later.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic r0, input logic r1, input logic p);
        if (r0 && r1) return p ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            rd[n] = 1'b0; wr[n] = 1'b0; lk[n] = 1'b0;
            addr[n] = '0; be[n] = '0; wd[n] = '0;
        end
    endtask

    // Called at posedge+1 with inputs set; checks returns and grant at the
    // falling edge, pushes expected read data, then moves to next posedge+1.
    task automatic do_cycle(input int eg, input string tag);
        logic [31:0] e;
        logic [11:0] a;
        @(negedge clk);
        if (q0.size() > 0) begin
            chk1({tag, "/rv0"}, rv[0], 1'b1);
            e = q0.pop_front();
            chk({tag, "/rdata0"}, rdat[0], e);
        end else begin
            chk1({tag, "/rv0"}, rv[0], 1'b0);
            chk({tag, "/rdata0"}, rdat[0], 32'h0);
        end
        if (q1.size() > 0) begin
            chk1({tag, "/rv1"}, rv[1], 1'b1);
            e = q1.pop_front();
            chk({tag, "/rdata1"}, rdat[1], e);
        end else begin
            chk1({tag, "/rv1"}, rv[1], 1'b0);
            chk({tag, "/rdata1"}, rdat[1], 32'h0);
        end
        chk1({tag, "/wait0"}, wreq[0], (rd[0] | wr[0]) && (eg != 0));
        chk1({tag, "/wait1"}, wreq[1], (rd[1] | wr[1]) && (eg != 1));
        chk1({tag, "/cs"}, ram_chipselect, eg >= 0);
        if (eg >= 0) begin
            a = addr[eg];
            chk({tag, "/addr"}, {20'h0, ram_address}, {20'h0, a});
            chk1({tag, "/ramwr"}, ram_write, wr[eg]);
            if (wr[eg]) begin
                chk({tag, "/wdata"}, ram_writedata, wd[eg]);
                chk({tag, "/be"}, {28'h0, ram_byteenable}, {28'h0, be[eg]});
                for (int b = 0; b < 4; b++)
                    if (be[eg][b]) shadow[a][8*b +: 8] = wd[eg][8*b +: 8];
            end else begin
                chk({tag, "/be_rd"}, {28'h0, ram_byteenable}, 32'hF);
                if (eg == 0) q0.push_back(shadow[a]);
                else         q1.push_back(shadow[a]);
            end
            exp_prio = (eg == 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted at posedge+1, checked at once, released one cycle later.
    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_prio = 1'b0;
        #1;
        chk1("rst/wait0", wreq[0], 1'b1);
        chk1("rst/wait1", wreq[1], 1'b1);
        chk1("rst/cs", ram_chipselect, 1'b0);
        chk1("rst/clken", ram_clken, 1'b0);
        chk1("rst/rv0", rv[0], 1'b0);
        chk1("rst/rv1", rv[1], 1'b0);
        chk("rst/rdata1", rdat[1], 32'h0);
        chk1("rst/ramwr", ram_write, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    // Writes from both ports; seq holds the expected grant of each cycle.
    task automatic run_writes(input int nw0, input int nw1, input logic lk0,
                              input logic [11:0] b0, input logic [11:0] b1, input string tag);
        int k0;
        int k1;
        k0 = 0;
        k1 = 0;
        foreach (seq[i]) begin
            wr[0] = (k0 < nw0); lk[0] = lk0 && (k0 < nw0); be[0] = 4'hF;
            addr[0] = b0 + 12'(k0); wd[0] = 32'hA000_0000 + 32'(k0);
            wr[1] = (k1 < nw1); be[1] = 4'hF;
            addr[1] = b1 + 12'(k1); wd[1] = 32'hB000_0000 + 32'(k1);
            do_cycle(seq[i], $sformatf("%s%0d", tag, i));
            if (seq[i] == 0) k0++;
            else if (seq[i] == 1) k1++;
        end
        clear_inputs();
    endtask

    initial begin
        int k0;
        int k1;
        int g;
        total    = 0;
        bad      = 0;
        exp_prio = 1'b0;
        reset_n  = 1'b0;
        clear_inputs();
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        mem[12'h010] = 32'hDEAD_BEEF; shadow[12'h010] = 32'hDEAD_BEEF;
        mem[12'h020] = 32'hAAAA_AAAA; shadow[12'h020] = 32'hAAAA_AAAA;

        @(posedge clk);
        #1;
        apply_reset();
        chk1("rel/clken", ram_clken, 1'b1);
        chk1("rel/wait0", wreq[0], 1'b0);
        chk1("rel/wait1", wreq[1], 1'b0);

        // Both ports write back to back: grants alternate starting with m0.
        seq.delete();
        for (int i = 0; i < 7; i++) seq.push_back(i % 2);
        run_writes(4, 3, 1'b0, 12'h100, 12'h200, "alt");
        for (int k = 0; k < 4; k++)
            chk($sformatf("alt_mem0_%0d", k), mem[12'h100 + 12'(k)], 32'hA000_0000 + 32'(k));
        for (int k = 0; k < 3; k++)
            chk($sformatf("alt_mem1_%0d", k), mem[12'h200 + 12'(k)], 32'hB000_0000 + 32'(k));

        // Single read from m0.
        rd[0] = 1'b1; addr[0] = 12'h010;
        do_cycle(0, "rd0");
        clear_inputs();
        do_cycle(-1, "rd0_ret");

        // Partial write, read back from m1, then an m0 write under the return.
        wr[0] = 1'b1; addr[0] = 12'h020; wd[0] = 32'h1234_5678; be[0] = 4'h3;
        do_cycle(0, "be_wr");
        clear_inputs();
        rd[1] = 1'b1; addr[1] = 12'h020;
        do_cycle(1, "be_rd");
        clear_inputs();
        wr[0] = 1'b1; addr[0] = 12'h030; wd[0] = 32'h0000_0055; be[0] = 4'hF;
        do_cycle(0, "rd_then_wr");
        clear_inputs();
        do_cycle(-1, "drain1");
        chk("be_mem", mem[12'h020], 32'hAAAA_5678);

        // Back-to-back reads from both ports.
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 4; i++) begin
            rd[0] = (k0 < 2); addr[0] = 12'h010;
            rd[1] = (k1 < 2); addr[1] = 12'h020;
            g = rr_pick(rd[0], rd[1], exp_prio);
            do_cycle(g, $sformatf("b2b%0d", i));
            if (g == 0) k0++;
            else if (g == 1) k1++;
        end
        clear_inputs();
        do_cycle(-1, "drain2");

        apply_reset();
        seq.delete();
`ifdef FTOP_OC_RAM_ARB_LOCK_EN
        for (int i = 0; i < 8; i++) seq.push_back(0);
        seq.push_back(1);
        seq.push_back(0);
        run_writes(9, 1, 1'b1, 12'h300, 12'h380, "lock");
        chk("lock_mem1", mem[12'h380], 32'hB000_0000);
`else
        for (int i = 0; i < 4; i++) seq.push_back(i % 2);
        run_writes(2, 2, 1'b1, 12'h300, 12'h380, "nolock");
        chk("nolock_mem1", mem[12'h381], 32'hB000_0001);
`endif
        apply_reset();

        // Reset lands in the return cycle of an m1 read: the return is dropped.
        rd[1] = 1'b1; addr[1] = 12'h020;
        do_cycle(1, "rst_rd");
        apply_reset();
        chk1("post_rst/wait0", wreq[0], 1'b0);
        chk1("post_rst/wait1", wreq[1], 1'b0);
        rd[0] = 1'b1; addr[0] = 12'h010;
        rd[1] = 1'b1; addr[1] = 12'h020;
        do_cycle(0, "post_rst_g0");
        rd[0] = 1'b0;
        do_cycle(1, "post_rst_g1");
        clear_inputs();
        do_cycle(-1, "drain3");

        chk("sb_empty0", q0.size(), 32'h0);
        chk("sb_empty1", q1.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
